// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 state-RAM datapath.
package rc4_pkg;

    localparam int RC4_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        READING,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry shift FIFO. The head always sits in entry0, so the outputs never depend on a pointer.
module sync_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign head    = entry0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            if (push_ok && pop_ok) begin
                // Count is unchanged; the surviving entry moves up ahead of the new one.
                if (count == 2'd1) begin
                    entry0 <= push_data;
                end else begin
                    entry0 <= entry1;
                    entry1 <= push_data;
                end
            end else if (push_ok) begin
                if (count == 2'd0) begin
                    entry0 <= push_data;
                end else begin
                    entry1 <= push_data;
                end
                count <= count + 2'd1;
            end else if (pop_ok) begin
                entry0 <= entry1;
                count  <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/ram_sweep_reader.sv
// Sweeps a synchronous-read RAM over a fixed address range and streams (address, data) pairs
// downstream, optionally counting words whose data differs from their address.
module ram_sweep_reader
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int START_INDEX    = 0,
    parameter int END_INDEX      = 255,
    parameter int CHECK_IDENTITY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 finished,
    output logic [RAM_WIDTH-1:0] address,
    input  logic [RAM_WIDTH-1:0] ram_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RAM_WIDTH-1:0] out_addr,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic [RAM_WIDTH-1:0] error_count
);

    localparam logic [RAM_WIDTH-1:0] START_ADDR = RAM_WIDTH'(START_INDEX);
    localparam logic [RAM_WIDTH-1:0] END_ADDR   = RAM_WIDTH'(END_INDEX);

    reader_state_t              state;
    logic                       start_d;
    logic                       rd_pending;
    logic [RAM_WIDTH-1:0]       tag;
    logic [1:0]                 count;
    logic [2*RAM_WIDTH-1:0]     head;
    logic                       pop;
    logic                       issue;
    logic                       start_edge;

    assign start_edge = start & ~start_d;
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid & out_ready;
    assign out_addr   = head[2*RAM_WIDTH-1:RAM_WIDTH];
    assign out_data   = head[RAM_WIDTH-1:0];
    assign busy       = (state != IDLE);

    // Credit check: buffered words plus the read in flight, less this cycle's pop, must leave room.
    assign issue = (state == READING) &&
                   (({1'b0, count} + {2'b00, rd_pending}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_d     <= 1'b0;
            rd_pending  <= 1'b0;
            tag         <= '0;
            address     <= START_ADDR;
            error_count <= '0;
            finished    <= 1'b0;
        end else begin
            start_d    <= start;
            finished   <= 1'b0;
            rd_pending <= issue;
            if (issue) begin
                tag <= address;
            end
            if (rd_pending && (CHECK_IDENTITY != 0) && (ram_q != tag) && (error_count != '1)) begin
                error_count <= error_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    address <= START_ADDR;
                    if (start_edge) begin
                        error_count <= '0;
                        state       <= READING;
                    end
                end
                READING: begin
                    if (issue) begin
                        if (address == END_ADDR) begin
                            address <= START_ADDR;
                            state   <= DRAIN;
                        end else begin
                            address <= address + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!rd_pending && (count == 2'd1) && pop) begin
                        finished <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo2 #(
        .WIDTH(2 * RAM_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_pending),
        .push_data({tag, ram_q}),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );

endmodule

// File: tb/tb_ram_sweep_reader.sv
// Directed bench for ram_sweep_reader: full sweeps, backpressure, mid-sweep reset, single-location sweep.
module tb_ram_sweep_reader;
    import rc4_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, finished, out_valid;
    logic [7:0] address, ram_q, out_addr, out_data, error_count;

    logic       start_7 = 1'b0;
    logic       out_ready_7 = 1'b0;
    logic       busy_7, finished_7, out_valid_7;
    logic [7:0] address_7, ram_q_7, out_addr_7, out_data_7, error_count_7;

    logic [7:0] mem [RC4_MEM_DEPTH];

    int n_vec = 0;
    int n_err = 0;
    int n_words, bad_order, bad_data, acc_cyc, fin_cyc, max_ahead;
    bit got_fin;

    ram_sweep_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
        .address(address), .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .error_count(error_count)
    );

    ram_sweep_reader #(
        .RAM_WIDTH(8), .START_INDEX(7), .END_INDEX(7), .CHECK_IDENTITY(1)
    ) dut7 (
        .clk(clk), .reset(reset), .start(start_7), .busy(busy_7), .finished(finished_7),
        .address(address_7), .ram_q(ram_q_7), .out_valid(out_valid_7),
        .out_ready(out_ready_7), .out_addr(out_addr_7), .out_data(out_data_7),
        .error_count(error_count_7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_q   <= mem[address];
        ram_q_7 <= mem[address_7];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input bit reversed);
        for (int i = 0; i < RC4_MEM_DEPTH; i++) begin
            mem[i] = reversed ? 8'(255 - i) : 8'(i);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1. stop_after > 0 returns early at that word.
    task automatic sweep(input bit do_start, input int mode, input int stop_after, input int max_cycles);
        n_words = 0; bad_order = 0; bad_data = 0;
        acc_cyc = -1; fin_cyc = -1; max_ahead = 0; got_fin = 1'b0;
        if (do_start) pulse_start();
        for (int c = 0; c < max_cycles; c++) begin
            if (finished) begin
                got_fin = 1'b1;
                fin_cyc = c;
                return;
            end
            if (stop_after > 0 && n_words == stop_after) return;
            out_ready = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            if (busy && int'(address) >= n_words && int'(address) - n_words > max_ahead)
                max_ahead = int'(address) - n_words;
            if (out_valid && out_ready) begin
                if (int'(out_addr) != n_words) bad_order++;
                if (out_data != mem[out_addr]) bad_data++;
                n_words++;
                acc_cyc = c;
            end
            @(negedge clk);
        end
        check("sweep_timeout", 1, 0);
    endtask

    task automatic check_full(input string pfx);
        check({pfx, "_words"}, n_words, 256);
        check({pfx, "_order"}, bad_order, 0);
        check({pfx, "_data"}, bad_data, 0);
        check({pfx, "_fin_seen"}, int'(got_fin), 1);
        check({pfx, "_fin_lat"}, fin_cyc - acc_cyc, 1);
        @(negedge clk);
        check({pfx, "_fin_pulse"}, int'(finished), 0);
        check({pfx, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int bp_bad;
        int n7;
        fill(1'b0);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_address", int'(address), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_out_addr", int'(out_addr), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_errcnt", int'(error_count), 0);
        @(negedge clk);
        reset = 1'b0;

        // Identity RAM, streaming.
        sweep(1'b1, 0, 0, 400);
        check_full("ident");
        check("ident_errcnt", int'(error_count), 0);

        // Reversed RAM: every location mismatches, count saturates.
        fill(1'b1);
        sweep(1'b1, 0, 0, 400);
        check_full("rev");
        check("rev_errcnt", int'(error_count), 255);

        // Reset at word 100 of a reversed-RAM sweep.
        sweep(1'b1, 0, 100, 400);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_addr", int'(out_addr), 100);
        check("pre_rst_err_nz", int'(error_count != 0), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_address", int'(address), 0);
        check("mid_rst_out_addr", int'(out_addr), 0);
        check("mid_rst_out_data", int'(out_data), 0);
        check("mid_rst_errcnt", int'(error_count), 0);
        check("mid_rst_finished", int'(finished), 0);
        @(negedge clk);
        reset = 1'b0;
        fill(1'b0);
        sweep(1'b1, 0, 0, 400);
        check_full("restart");
        check("restart_errcnt", int'(error_count), 0);

        // Ready pattern 1,0,0,1.
        sweep(1'b1, 1, 0, 1200);
        check_full("toggle");
        check("toggle_ahead_gt2", int'(max_ahead > 2), 0);

        // Ready held low for 20 cycles after start.
        out_ready = 1'b0;
        pulse_start();
        bp_bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c >= 3 && (!out_valid || out_addr != 8'd0 || address != 8'd2)) bp_bad++;
            @(negedge clk);
        end
        check("bp_hold_bad", bp_bad, 0);
        check("bp_out_addr", int'(out_addr), 0);
        check("bp_address", int'(address), 2);
        sweep(1'b0, 0, 0, 400);
        check_full("bp_resume");

        // Single-location sweep with a start re-pulse while busy.
        check("one_idle_address", int'(address_7), 7);
        start_7 = 1'b1;
        @(negedge clk);
        start_7 = 1'b0;
        repeat (4) @(negedge clk);
        start_7 = 1'b1;
        @(negedge clk);
        start_7 = 1'b0;
        check("one_busy", int'(busy_7), 1);
        check("one_valid", int'(out_valid_7), 1);
        check("one_out_addr", int'(out_addr_7), 7);
        check("one_out_data", int'(out_data_7), 7);
        out_ready_7 = 1'b1;
        @(negedge clk);
        check("one_finished", int'(finished_7), 1);
        check("one_busy_after", int'(busy_7), 0);
        n7 = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid_7 || busy_7) n7++;
            @(negedge clk);
        end
        check("one_no_second_sweep", n7, 0);
        check("one_errcnt", int'(error_count_7), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
